// File: rtl/sargam_pkg.sv
// rtl/sargam_pkg.sv - shared types and constants for the sargam tone sequencer
//
// Purpose: note encoding, sequencer state enum, melody step entry and table
// types, the default melody, the tone generator half-period constants and
// the manual-button priority helper.
// Ports: none (package).

package sargam_pkg;

  // Clock the half-period constants are derived for.
  localparam int unsigned CLK_HZ = 50_000_000;

  // Note encoding shared with the tone generator datapath.
  localparam logic [2:0] SA   = 3'd0;
  localparam logic [2:0] RE   = 3'd1;
  localparam logic [2:0] GA   = 3'd2;
  localparam logic [2:0] MA   = 3'd3;
  localparam logic [2:0] PA   = 3'd4;
  localparam logic [2:0] DHA  = 3'd5;
  localparam logic [2:0] NI   = 3'd6;
  localparam logic [2:0] REST = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    GAP    = 2'd2,
    MANUAL = 2'd3
  } state_t;

  // One melody step; beats = 0 plays as a single beat.
  typedef struct packed {
    logic [2:0] note;
    logic [2:0] beats;
  } step_t;

  localparam int MAX_STEPS = 16;
  typedef step_t [MAX_STEPS-1:0] table_t;

  function automatic step_t mk_step(input logic [2:0] n, input logic [2:0] b);
    step_t s;
    s.note  = n;
    s.beats = b;
    return s;
  endfunction

  // Ascending Sa..Ni, Sa held for two beats, descending Ni..Sa, closing rest.
  // Element 0 is the rightmost term of the concatenation.
  localparam table_t DEFAULT_TABLE = {
    mk_step(REST, 3'd1), mk_step(SA, 3'd1), mk_step(RE, 3'd1), mk_step(GA, 3'd1),
    mk_step(MA, 3'd1),   mk_step(PA, 3'd1), mk_step(DHA, 3'd1), mk_step(NI, 3'd1),
    mk_step(SA, 3'd2),   mk_step(NI, 3'd1), mk_step(DHA, 3'd1), mk_step(PA, 3'd1),
    mk_step(MA, 3'd1),   mk_step(GA, 3'd1), mk_step(RE, 3'd1), mk_step(SA, 3'd1)
  };

  // Half-period in clk cycles for each note (Sa at roughly 262 Hz).
  localparam int unsigned HALF_SA  = CLK_HZ / (2 * 262);
  localparam int unsigned HALF_RE  = CLK_HZ / (2 * 294);
  localparam int unsigned HALF_GA  = CLK_HZ / (2 * 330);
  localparam int unsigned HALF_MA  = CLK_HZ / (2 * 349);
  localparam int unsigned HALF_PA  = CLK_HZ / (2 * 392);
  localparam int unsigned HALF_DHA = CLK_HZ / (2 * 440);
  localparam int unsigned HALF_NI  = CLK_HZ / (2 * 494);

  // Lowest set button wins; REST when no button is pressed.
  function automatic logic [2:0] lowest_btn(input logic [6:0] b);
    logic [2:0] idx;
    idx = REST;
    for (int i = 6; i >= 0; i--) begin
      if (b[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sargam_beat_timer.sv
// rtl/sargam_beat_timer.sv - loadable down-counter shared by beat and gap timing
//
// Purpose: counts down once per cycle while not frozen, stopping at zero.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   load         load load_val this cycle (overrides freeze)
//   load_val     W-bit reload value
//   freeze       hold the current count
//   tc           count is 1, i.e. this is the last cycle of the interval

module sargam_beat_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         freeze,
  output logic         tc
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (!freeze && count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign tc = (count_q == W'(1));

endmodule

// File: rtl/sargam_sequencer.sv
// rtl/sargam_sequencer.sv - melody sequencer and manual/autoplay arbiter for the tone generator
//
// Purpose: steps through SEQ_TABLE (note, beats), inserting GAP_CYC silent
// cycles after each step; manual buttons preempt autoplay, freezing timing.
// Build option: SARGAM_SEQ_LOOP_EN repeats the sequence until stop instead of
// ending with a done pulse.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   btn[6:0]    manual note buttons, bit 0 = Sa .. bit 6 = Ni
//   play        rising edge starts the sequence from IDLE
//   stop        aborts to IDLE
//   note_idx    0..6 = Sa..Ni, 7 = rest
//   note_on     tone generator enable
//   led[6:0]    one-hot of note_idx while note_on
//   busy        high in PLAY, GAP, MANUAL
//   done        one-cycle pulse at natural end of the sequence
//   step[3:0]   current table index

module sargam_sequencer
  import sargam_pkg::*;
#(
  parameter int     BEAT_CYC  = 12_500_000,
  parameter int     GAP_CYC   = 1_250_000,
  parameter int     SEQ_LEN   = 16,
  parameter table_t SEQ_TABLE = DEFAULT_TABLE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] btn,
  input  logic       play,
  input  logic       stop,
  output logic [2:0] note_idx,
  output logic       note_on,
  output logic [6:0] led,
  output logic       busy,
  output logic       done,
  output logic [3:0] step
);

  localparam int         CW   = $clog2(7 * BEAT_CYC + 1);
  localparam logic [3:0] LAST = 4'(SEQ_LEN - 1);

  function automatic logic [CW-1:0] beat_load(input step_t e);
    logic [2:0] b;
    b = (e.beats == 3'd0) ? 3'd1 : e.beats;
    return CW'(b) * CW'(BEAT_CYC);
  endfunction

  state_t        state_q, state_n, save_q, save_n;
  logic [3:0]    step_q, step_n, step_inc;
  logic [2:0]    idx_q, idx_n, win;
  logic          on_q, on_n, done_q, done_n, busy_q, play_q;
  logic [6:0]    led_q, led_n;
  logic          load, tc, freeze, btn_any, play_edge;
  logic [CW-1:0] load_val;
  step_t         entry;

  assign btn_any   = |btn;
  assign win       = lowest_btn(btn);
  assign play_edge = play & ~play_q;
  assign step_inc  = step_q + 4'd1;
  // The timer only runs while the sequence itself owns the tone generator.
  assign freeze    = !(state_q == PLAY || state_q == GAP);

  sargam_beat_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .freeze   (freeze),
    .tc       (tc)
  );

  always_comb begin
    state_n  = state_q;
    save_n   = save_q;
    step_n   = step_q;
    load     = 1'b0;
    load_val = '0;
    done_n   = 1'b0;
    idx_n    = REST;
    on_n     = 1'b0;
    entry    = SEQ_TABLE[0];

    // Sequence progression as if no button were pressed.
    unique case (state_q)
      IDLE: begin
        if (play_edge) begin
          state_n  = PLAY;
          step_n   = 4'd0;
          load     = 1'b1;
          load_val = beat_load(SEQ_TABLE[0]);
        end
      end
      PLAY: begin
        if (tc) begin
          state_n  = GAP;
          load     = 1'b1;
          load_val = CW'(GAP_CYC);
        end
      end
      GAP: begin
        if (tc) begin
          if (step_q == LAST) begin
`ifdef SARGAM_SEQ_LOOP_EN
            state_n  = PLAY;
            step_n   = 4'd0;
            load     = 1'b1;
            load_val = beat_load(SEQ_TABLE[0]);
`else
            state_n  = IDLE;
            step_n   = 4'd0;
            done_n   = 1'b1;
`endif
          end else begin
            state_n  = PLAY;
            step_n   = step_inc;
            load     = 1'b1;
            load_val = beat_load(SEQ_TABLE[step_inc]);
          end
        end
      end
      MANUAL: begin
        if (!btn_any) state_n = save_q;
      end
      default: state_n = IDLE;
    endcase

    // Preemption overlays the progression: the cycle that takes us into
    // MANUAL still counts, so autoplay time excludes exactly the manual window.
    if ((state_q == PLAY || state_q == GAP) && btn_any &&
        (state_n == PLAY || state_n == GAP)) begin
      save_n  = state_n;
      state_n = MANUAL;
    end

    if (stop) begin
      state_n  = IDLE;
      step_n   = 4'd0;
      load     = 1'b1;
      load_val = '0;
      done_n   = 1'b0;
    end

    // Outputs follow the next state so they are registered with it.
    unique case (state_n)
      IDLE: begin
        if (btn_any && !stop) begin
          idx_n = win;
          on_n  = 1'b1;
        end
      end
      PLAY: begin
        entry = SEQ_TABLE[step_n];
        idx_n = entry.note;
        on_n  = (entry.note != REST);
      end
      MANUAL: begin
        idx_n = win;
        on_n  = 1'b1;
      end
      default: begin
        idx_n = REST;
        on_n  = 1'b0;
      end
    endcase

    led_n = on_n ? (7'd1 << idx_n) : 7'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      save_q  <= IDLE;
      step_q  <= 4'd0;
      idx_q   <= REST;
      on_q    <= 1'b0;
      led_q   <= 7'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      play_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      save_q  <= save_n;
      step_q  <= step_n;
      idx_q   <= idx_n;
      on_q    <= on_n;
      led_q   <= led_n;
      busy_q  <= (state_n != IDLE);
      done_q  <= done_n;
      play_q  <= play;
    end
  end

  assign note_idx = idx_q;
  assign note_on  = on_q;
  assign led      = led_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step     = step_q;

endmodule

// File: tb/tb_sargam_sequencer.sv
// tb/tb_sargam_sequencer.sv - self-checking bench for sargam_sequencer

module tb_sargam_sequencer;
  import sargam_pkg::*;

  // {Sa,1},{Ga,2},{rest,1},{Ni,0}; entry 0 is the rightmost field.
  localparam table_t TB_TABLE = table_t'({72'd0, 6'o60, 6'o71, 6'o22, 6'o01});

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] btn = 7'd0;
  logic       play = 1'b0;
  logic       stop = 1'b0;
  logic [2:0] note_idx;
  logic       note_on;
  logic [6:0] led;
  logic       busy;
  logic       done;
  logic [3:0] step;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit mon_en = 1'b1;

  typedef struct {
    logic       on;
    logic [2:0] idx;
    logic [3:0] st;
    int         len;
  } seg_t;
  seg_t exp_q[$];

  always #5 clk = ~clk;

  sargam_sequencer #(
    .BEAT_CYC (4),
    .GAP_CYC  (2),
    .SEQ_LEN  (4),
    .SEQ_TABLE(TB_TABLE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .play     (play),
    .stop     (stop),
    .note_idx (note_idx),
    .note_on  (note_on),
    .led      (led),
    .busy     (busy),
    .done     (done),
    .step     (step)
  );

  // Segment monitor: a run of constant {busy,note_on,note_idx,step} while busy
  // is one segment; each finished busy segment is checked against the queue.
  logic [8:0] prev_key = 9'h0;
  logic [8:0] cur_key;
  int         seg_len = 0;
  seg_t       e;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    cur_key = {busy, note_on, note_idx, step};
    if (cur_key !== prev_key) begin
      if (prev_key[8] === 1'b1 && mon_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL seg_unexpected: got on=%0b idx=%0d step=%0d len=%0d, none expected",
                   prev_key[7], prev_key[6:4], prev_key[3:0], seg_len);
        end else begin
          e = exp_q.pop_front();
          if (prev_key[7] !== e.on || prev_key[6:4] !== e.idx ||
              prev_key[3:0] !== e.st || seg_len != e.len) begin
            errors++;
            $display("FAIL seg: got on=%0b idx=%0d step=%0d len=%0d, expected on=%0b idx=%0d step=%0d len=%0d",
                     prev_key[7], prev_key[6:4], prev_key[3:0], seg_len, e.on, e.idx, e.st, e.len);
          end
        end
      end
      prev_key = cur_key;
      seg_len  = 1;
    end else begin
      seg_len++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic exp_seg(input logic on, input logic [2:0] idx, input logic [3:0] st, input int len);
    seg_t s;
    s.on = on; s.idx = idx; s.st = st; s.len = len;
    exp_q.push_back(s);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn = 7'd0; play = 1'b0; stop = 1'b0;
    tick(); tick();
    checks++; if (note_idx !== REST) begin errors++; $display("FAIL reset_idx: got %0d expected 7", note_idx); end
    checks++; if (note_on !== 1'b0) begin errors++; $display("FAIL reset_on: got %0b expected 0", note_on); end
    checks++; if (led !== 7'd0) begin errors++; $display("FAIL reset_led: got %b expected 0", led); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %0b%0b expected 00", busy, done); end
    checks++; if (step !== 4'd0) begin errors++; $display("FAIL reset_step: got %0d expected 0", step); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_manual_idle();
    btn = 7'b0101000;
    tick();
    checks++; if (note_on !== 1'b1 || note_idx !== MA) begin errors++; $display("FAIL idle_btn: got on=%0b idx=%0d expected on=1 idx=3", note_on, note_idx); end
    checks++; if (led !== 7'b0001000 || busy !== 1'b0) begin errors++; $display("FAIL idle_btn_led: got led=%b busy=%0b expected 0001000/0", led, busy); end
    btn = 7'b1000000;
    tick();
    checks++; if (note_idx !== NI || led !== 7'b1000000) begin errors++; $display("FAIL idle_btn_ni: got idx=%0d led=%b expected 6/1000000", note_idx, led); end
    btn = 7'd0;
    tick();
    checks++; if (note_on !== 1'b0 || note_idx !== REST || led !== 7'd0) begin errors++; $display("FAIL idle_release: got on=%0b idx=%0d led=%b expected 0/7/0", note_on, note_idx, led); end
  endtask

  task automatic test_sequence();
    int guard;
    int busy_cyc;
    int d0;
    bit seen3;
    d0 = done_cnt;
`ifdef SARGAM_SEQ_LOOP_EN
    mon_en = 1'b0;
    play = 1'b1; tick(); play = 1'b0;
    guard = 0; seen3 = 1'b0;
    while (!(seen3 && step === 4'd0) && guard < 200) begin
      tick(); guard++;
      if (step === 4'd3) seen3 = 1'b1;
    end
    checks++; if (!(seen3 && step === 4'd0 && busy === 1'b1 && note_idx === SA)) begin errors++; $display("FAIL loop_wrap: got step=%0d busy=%0b idx=%0d expected step=0 busy=1 idx=0", step, busy, note_idx); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL loop_done: got %0d pulses expected 0", done_cnt - d0); end
    stop = 1'b1; tick(); stop = 1'b0;
    checks++; if (busy !== 1'b0 || step !== 4'd0) begin errors++; $display("FAIL loop_stop: got busy=%0b step=%0d expected 0/0", busy, step); end
    tick();
    mon_en = 1'b1;
`else
    exp_seg(1'b1, SA, 4'd0, 4);
    exp_seg(1'b0, REST, 4'd0, 2);
    exp_seg(1'b1, GA, 4'd1, 8);
    exp_seg(1'b0, REST, 4'd1, 2);
    exp_seg(1'b0, REST, 4'd2, 6);
    exp_seg(1'b1, NI, 4'd3, 4);
    exp_seg(1'b0, REST, 4'd3, 2);
    play = 1'b1;
    tick();
    play = 1'b0;
    checks++; if (note_on !== 1'b1 || note_idx !== SA || busy !== 1'b1 || led !== 7'b0000001) begin errors++; $display("FAIL play_latency: got on=%0b idx=%0d busy=%0b led=%b expected 1/0/1/0000001", note_on, note_idx, busy, led); end
    busy_cyc = 1; guard = 0;
    while (busy === 1'b1 && guard < 200) begin
      tick(); guard++;
      if (busy === 1'b1) busy_cyc++;
    end
    checks++; if (busy !== 1'b0 || busy_cyc != 28) begin errors++; $display("FAIL seq_length: got busy=%0b cycles=%0d expected 0/28", busy, busy_cyc); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_on_busy_fall: got %0b expected 1", done); end
    tick();
    checks++; if (done !== 1'b0 || done_cnt - d0 != 1) begin errors++; $display("FAIL done_pulse: got done=%0b pulses=%0d expected 0/1", done, done_cnt - d0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL seq_segments: got %0d pending expected 0", exp_q.size()); end
`endif
  endtask

  task automatic test_preempt();
    exp_seg(1'b1, SA, 4'd0, 4);
    exp_seg(1'b0, REST, 4'd0, 2);
    exp_seg(1'b1, GA, 4'd1, 13);
    exp_seg(1'b0, REST, 4'd1, 2);
    exp_seg(1'b0, REST, 4'd2, 1);
    play = 1'b1; tick(); play = 1'b0;
    repeat (7) tick();
    btn = 7'b0010100;
    tick();
    checks++; if (note_idx !== GA || note_on !== 1'b1 || busy !== 1'b1 || step !== 4'd1 || led !== 7'b0000100) begin errors++; $display("FAIL manual_win: got idx=%0d on=%0b busy=%0b step=%0d led=%b expected 2/1/1/1/0000100", note_idx, note_on, busy, step, led); end
    repeat (4) tick();
    btn = 7'd0;
    tick();
    checks++; if (note_idx !== GA || note_on !== 1'b1 || step !== 4'd1) begin errors++; $display("FAIL manual_resume: got idx=%0d on=%0b step=%0d expected 2/1/1", note_idx, note_on, step); end
    repeat (8) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    checks++; if (busy !== 1'b0 || note_on !== 1'b0) begin errors++; $display("FAIL preempt_stop: got busy=%0b on=%0b expected 0/0", busy, note_on); end
    tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL preempt_segments: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_stop_play();
    int d0;
    d0 = done_cnt;
    exp_seg(1'b1, SA, 4'd0, 4);
    exp_seg(1'b0, REST, 4'd0, 2);
    exp_seg(1'b1, GA, 4'd1, 3);
    play = 1'b1; tick(); play = 1'b0;
    repeat (8) tick();
    stop = 1'b1; play = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || step !== 4'd0 || note_on !== 1'b0 || note_idx !== REST) begin errors++; $display("FAIL stop_play: got busy=%0b step=%0d on=%0b idx=%0d expected 0/0/0/7", busy, step, note_on, note_idx); end
    stop = 1'b0; play = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0 || done_cnt != d0) begin errors++; $display("FAIL stop_no_done: got busy=%0b pulses=%0d expected 0/0", busy, done_cnt - d0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stop_segments: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_gap();
    int d0;
    d0 = done_cnt;
    exp_seg(1'b1, SA, 4'd0, 4);
    exp_seg(1'b0, REST, 4'd0, 1);
    play = 1'b1; tick(); play = 1'b0;
    repeat (4) tick();
    checks++; if (busy !== 1'b1 || note_on !== 1'b0) begin errors++; $display("FAIL gap_entry: got busy=%0b on=%0b expected 1/0", busy, note_on); end
    rst_n = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || note_on !== 1'b0 || note_idx !== REST || led !== 7'd0 || step !== 4'd0 || done !== 1'b0) begin errors++; $display("FAIL reset_mid_gap: got busy=%0b on=%0b idx=%0d led=%b step=%0d done=%0b expected reset values", busy, note_on, note_idx, led, step, done); end
    rst_n = 1'b1;
    tick(); tick();
    checks++; if (done_cnt != d0 || busy !== 1'b0) begin errors++; $display("FAIL reset_no_done: got pulses=%0d busy=%0b expected 0/0", done_cnt - d0, busy); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL reset_segments: got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_manual_idle();
    test_sequence();
    test_preempt();
    test_stop_play();
    test_reset_mid_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
